// File: rtl/skip_seq.sv
// skip_seq: multi-channel clock-skip (pulse-swallow) sequencer with shadow-loaded skip rings.
// Define SKIP_GATED_CLK_EN to add glitch-free gated clock outputs oCLK.
module skip_lane #(
  parameter int LEN  = 16,
  parameter int LW   = 4,
  parameter int CNTW = 16
) (
  input  logic            iCLK,
  input  logic            iRSTn,
  input  logic            ereg,
  input  logic            ld,
  input  logic [LEN-1:0]  ipat,
  input  logic [LW-1:0]   ilen,
  input  logic            imode,
  output logic            ce,
  output logic            st,
  output logic            done,
  output logic            pend,
  output logic [CNTW-1:0] cnt
);
  localparam logic [LW-1:0] LMAX = LW'(LEN-1);

  logic [LEN-1:0] pat, spat;
  logic [LW-1:0]  len, slen, pos;
  logic           mode, smode;
  logic           swal, adv, wrap, apply;

  assign swal  = st & ereg & pat[pos];
  assign ce    = ~swal;
  assign adv   = st & ereg;
  assign wrap  = adv & (pos == len);
  // idle channels take the shadow at once; running ones only at the wrap edge
  assign apply = pend & (~st | wrap);

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      pat   <= '0;
      spat  <= '0;
      len   <= '0;
      slen  <= '0;
      mode  <= 1'b0;
      smode <= 1'b0;
      pos   <= '0;
      pend  <= 1'b0;
      st    <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
    end else begin
      if (ld) begin
        spat  <= ipat;
        slen  <= (ilen > LMAX) ? LMAX : ilen;
        smode <= imode;
        pend  <= 1'b1;
      end
      if (apply) begin
        pat  <= spat;
        len  <= slen;
        mode <= smode;
        pend <= 1'b0;
        pos  <= '0;
        cnt  <= '0;
        done <= 1'b0;
        st   <= 1'b1;
      end else begin
        if (wrap) begin
          pos <= '0;
          if (mode) begin
            st   <= 1'b0;
            done <= 1'b1;
          end
        end else if (adv) begin
          pos <= pos + 1'b1;
        end
        if (swal && (cnt != '1)) cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module skip_seq #(
  parameter int NCH  = 2,
  parameter int CHW  = 1,
  parameter int LEN  = 16,
  parameter int LW   = 4,
  parameter int CNTW = 16
) (
  input  logic                iCLK,
  input  logic                iRSTn,
  input  logic                iE,
  input  logic                iLD,
  input  logic [CHW-1:0]      iCH,
  input  logic [LEN-1:0]      iPAT,
  input  logic [LW-1:0]       iLEN,
  input  logic                iMODE,
  output logic                oRDY,
  output logic [NCH-1:0]      oCE,
  output logic [NCH-1:0]      oST,
  output logic [NCH-1:0]      oDONE,
  output logic [NCH*CNTW-1:0] oSKCNT
`ifdef SKIP_GATED_CLK_EN
  ,
  output logic [NCH-1:0]      oCLK
`endif
);
  logic                      ereg;
  logic [NCH-1:0]            pend, ld;
  logic [NCH-1:0][CNTW-1:0]  cnt;

  always_ff @(posedge iCLK or negedge iRSTn)
    if (!iRSTn) ereg <= 1'b0;
    else        ereg <= iE;

  // out-of-range channel numbers read as ready and never load anything
  always_comb begin
    oRDY = 1'b1;
    for (int c = 0; c < NCH; c++)
      if (iCH == CHW'(c)) oRDY = ~pend[c];
  end

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    assign ld[g] = iLD & ~pend[g] & (iCH == CHW'(g));
    skip_lane #(.LEN(LEN), .LW(LW), .CNTW(CNTW)) u_lane (
      .iCLK  (iCLK),
      .iRSTn (iRSTn),
      .ereg  (ereg),
      .ld    (ld[g]),
      .ipat  (iPAT),
      .ilen  (iLEN),
      .imode (iMODE),
      .ce    (oCE[g]),
      .st    (oST[g]),
      .done  (oDONE[g]),
      .pend  (pend[g]),
      .cnt   (cnt[g])
    );
  end

  assign oSKCNT = cnt;

`ifdef SKIP_GATED_CLK_EN
  // enable sampled while the clock is low, so each gated high phase is all or nothing
  logic [NCH-1:0] ceL;
  always_ff @(negedge iCLK or negedge iRSTn)
    if (!iRSTn) ceL <= '1;
    else        ceL <= oCE;
  assign oCLK = {NCH{iCLK}} & ceL;
`endif
endmodule

// File: tb/tb_skip_seq.sv
// Directed bench for skip_seq: ring patterns, reload at wrap, one-shot, freeze, saturation.
module tb_skip_seq;
  localparam int NCH = 2, CHW = 1, LEN = 16, LW = 4, CNTW = 4;

  logic iCLK = 1'b0, iRSTn = 1'b0, iE = 1'b0, iLD = 1'b0, iMODE = 1'b0;
  logic [CHW-1:0] iCH = '0;
  logic [LEN-1:0] iPAT = '0;
  logic [LW-1:0]  iLEN = '0;
  logic                oRDY;
  logic [NCH-1:0]      oCE, oST, oDONE;
  logic [NCH*CNTW-1:0] oSKCNT;
`ifdef SKIP_GATED_CLK_EN
  logic [NCH-1:0]      oCLK;
`endif
  int tests = 0, fails = 0;

  skip_seq #(.NCH(NCH), .CHW(CHW), .LEN(LEN), .LW(LW), .CNTW(CNTW)) dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iE(iE), .iLD(iLD), .iCH(iCH), .iPAT(iPAT),
    .iLEN(iLEN), .iMODE(iMODE), .oRDY(oRDY), .oCE(oCE), .oST(oST),
    .oDONE(oDONE), .oSKCNT(oSKCNT)
`ifdef SKIP_GATED_CLK_EN
    , .oCLK(oCLK)
`endif
  );

  always #5 iCLK = ~iCLK;

  task automatic cyc();
    @(posedge iCLK); #1;
  endtask

  task automatic do_reset();
    iRSTn = 1'b0; iLD = 1'b0; iE = 1'b1; iMODE = 1'b0; iCH = '0;
    repeat (2) cyc();
    iRSTn = 1'b1;
  endtask

  task automatic load(input int ch, input logic [LEN-1:0] p, input int l, input logic m);
    iLD = 1'b1; iCH = CHW'(ch); iPAT = p; iLEN = LW'(l); iMODE = m;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (oCE !== 2'b11) begin fails++; $display("FAIL rst_ce: got %b want 11", oCE); end
    tests++; if (oST !== 2'b00) begin fails++; $display("FAIL rst_st: got %b want 00", oST); end
    tests++; if (oDONE !== 2'b00) begin fails++; $display("FAIL rst_done: got %b want 00", oDONE); end
    tests++; if (oSKCNT !== 8'h00) begin fails++; $display("FAIL rst_cnt: got %h want 00", oSKCNT); end
    tests++; if (oRDY !== 1'b1) begin fails++; $display("FAIL rst_rdy: got %b want 1", oRDY); end
  endtask

  // ch0 pattern 0101 over 4 positions: swallow at even positions
  task automatic test_continuous();
    do_reset();
    load(0, 16'h0005, 3, 1'b0);
    cyc(); iLD = 1'b0;
    tests++; if (oRDY !== 1'b0) begin fails++; $display("FAIL t1_pend_rdy: got %b want 0", oRDY); end
    tests++; if (oST[0] !== 1'b0) begin fails++; $display("FAIL t1_pend_st: got %b want 0", oST[0]); end
    cyc();
    for (int i = 0; i < 8; i++) begin
      tests++; if (oCE[0] !== 1'(i % 2)) begin fails++; $display("FAIL t1_ce i%0d: got %b want %b", i, oCE[0], 1'(i % 2)); end
      tests++; if (oSKCNT[3:0] !== 4'((i + 1) / 2)) begin fails++; $display("FAIL t1_cnt i%0d: got %0d want %0d", i, oSKCNT[3:0], (i + 1) / 2); end
      cyc();
    end
  endtask

  // continues from test_continuous: ch0 at pos 0, count 4
  task automatic test_reload();
    tests++; if (oCE[0] !== 1'b0 || oSKCNT[3:0] !== 4'd4) begin fails++; $display("FAIL t2_entry: got ce=%b cnt=%0d want ce=0 cnt=4", oCE[0], oSKCNT[3:0]); end
    load(0, 16'h0001, 1, 1'b0);
    cyc();
    tests++; if (oRDY !== 1'b0) begin fails++; $display("FAIL t2_rdy_a: got %b want 0", oRDY); end
    tests++; if (oCE[0] !== 1'b1 || oSKCNT[3:0] !== 4'd5) begin fails++; $display("FAIL t2_s11: got ce=%b cnt=%0d want ce=1 cnt=5", oCE[0], oSKCNT[3:0]); end
    iPAT = 16'hFFFF; iLEN = '0;
    cyc(); iLD = 1'b0;
    tests++; if (oRDY !== 1'b0 || oCE[0] !== 1'b0 || oSKCNT[3:0] !== 4'd5) begin fails++; $display("FAIL t2_s12: got rdy=%b ce=%b cnt=%0d want 0 0 5", oRDY, oCE[0], oSKCNT[3:0]); end
    cyc();
    tests++; if (oRDY !== 1'b0 || oCE[0] !== 1'b1 || oSKCNT[3:0] !== 4'd6) begin fails++; $display("FAIL t2_s13: got rdy=%b ce=%b cnt=%0d want 0 1 6", oRDY, oCE[0], oSKCNT[3:0]); end
    cyc();
    tests++; if (oRDY !== 1'b1 || oCE[0] !== 1'b0 || oSKCNT[3:0] !== 4'd0) begin fails++; $display("FAIL t2_apply: got rdy=%b ce=%b cnt=%0d want 1 0 0", oRDY, oCE[0], oSKCNT[3:0]); end
    cyc();
    tests++; if (oCE[0] !== 1'b1 || oSKCNT[3:0] !== 4'd1) begin fails++; $display("FAIL t2_s15: got ce=%b cnt=%0d want 1 1", oCE[0], oSKCNT[3:0]); end
    cyc();
    tests++; if (oCE[0] !== 1'b0 || oSKCNT[3:0] !== 4'd1) begin fails++; $display("FAIL t2_s16: got ce=%b cnt=%0d want 0 1", oCE[0], oSKCNT[3:0]); end
  endtask

  task automatic test_oneshot();
    do_reset();
    load(1, 16'h0003, 2, 1'b1);
    cyc(); iLD = 1'b0;
    cyc();
    tests++; if (oCE[1] !== 1'b0 || oSKCNT[7:4] !== 4'd0) begin fails++; $display("FAIL t3_p0: got ce=%b cnt=%0d want 0 0", oCE[1], oSKCNT[7:4]); end
    cyc();
    tests++; if (oCE[1] !== 1'b0 || oSKCNT[7:4] !== 4'd1) begin fails++; $display("FAIL t3_p1: got ce=%b cnt=%0d want 0 1", oCE[1], oSKCNT[7:4]); end
    cyc();
    tests++; if (oCE[1] !== 1'b1 || oST[1] !== 1'b1 || oSKCNT[7:4] !== 4'd2) begin fails++; $display("FAIL t3_p2: got ce=%b st=%b cnt=%0d want 1 1 2", oCE[1], oST[1], oSKCNT[7:4]); end
    cyc();
    tests++; if (oST[1] !== 1'b0 || oDONE[1] !== 1'b1 || oCE[1] !== 1'b1) begin fails++; $display("FAIL t3_end: got st=%b done=%b ce=%b want 0 1 1", oST[1], oDONE[1], oCE[1]); end
    cyc();
    tests++; if (oCE !== 2'b11 || oDONE !== 2'b10 || oSKCNT[7:4] !== 4'd2) begin fails++; $display("FAIL t3_hold: got ce=%b done=%b cnt=%0d want 11 10 2", oCE, oDONE, oSKCNT[7:4]); end
    load(1, 16'h0000, 0, 1'b0);
    cyc(); iLD = 1'b0;
    tests++; if (oDONE[1] !== 1'b1 || oRDY !== 1'b0) begin fails++; $display("FAIL t3_pend: got done=%b rdy=%b want 1 0", oDONE[1], oRDY); end
    cyc();
    tests++; if (oDONE[1] !== 1'b0 || oST[1] !== 1'b1) begin fails++; $display("FAIL t3_reapply: got done=%b st=%b want 0 1", oDONE[1], oST[1]); end
  endtask

  // ch0 pattern swallows pos 2 only; iE drops with pos 2 next
  task automatic test_freeze();
    do_reset();
    load(0, 16'h0004, 3, 1'b0);
    cyc(); iLD = 1'b0;
    cyc();
    tests++; if (oCE[0] !== 1'b1) begin fails++; $display("FAIL t4_p0: got %b want 1", oCE[0]); end
    cyc(); iE = 1'b0;
    cyc();
    load(1, 16'h0001, 0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tests++; if (oCE[0] !== 1'b1 || oSKCNT[3:0] !== 4'd0) begin fails++; $display("FAIL t4_frz k%0d: got ce=%b cnt=%0d want 1 0", k, oCE[0], oSKCNT[3:0]); end
      if (k == 1) iLD = 1'b0;
      if (k == 2) begin
        tests++; if (oST[1] !== 1'b1 || oCE[1] !== 1'b1) begin fails++; $display("FAIL t4_idle_apply: got st=%b ce=%b want 1 1", oST[1], oCE[1]); end
      end
      if (k == 4) iE = 1'b1;
      cyc();
    end
    tests++; if (oCE !== 2'b00 || oSKCNT[3:0] !== 4'd0) begin fails++; $display("FAIL t4_resume: got ce=%b cnt=%0d want 00 0", oCE, oSKCNT[3:0]); end
    cyc();
    tests++; if (oCE[0] !== 1'b1 || oSKCNT[3:0] !== 4'd1) begin fails++; $display("FAIL t4_p3: got ce=%b cnt=%0d want 1 1", oCE[0], oSKCNT[3:0]); end
  endtask

  task automatic test_saturate();
    do_reset();
    load(0, 16'h0001, 0, 1'b0);
    cyc(); iLD = 1'b0;
    cyc();
    tests++; if (oCE[0] !== 1'b0 || oSKCNT[3:0] !== 4'd0) begin fails++; $display("FAIL t5_start: got ce=%b cnt=%0d want 0 0", oCE[0], oSKCNT[3:0]); end
    repeat (14) cyc();
    tests++; if (oSKCNT[3:0] !== 4'd14) begin fails++; $display("FAIL t5_14: got %0d want 14", oSKCNT[3:0]); end
    cyc();
    tests++; if (oSKCNT[3:0] !== 4'd15) begin fails++; $display("FAIL t5_15: got %0d want 15", oSKCNT[3:0]); end
    repeat (5) cyc();
    tests++; if (oSKCNT[3:0] !== 4'd15 || oCE[0] !== 1'b0) begin fails++; $display("FAIL t5_sat: got cnt=%0d ce=%b want 15 0", oSKCNT[3:0], oCE[0]); end
    #3 iRSTn = 1'b0;
    #1;
    tests++; if (oCE !== 2'b11 || oST !== 2'b00 || oSKCNT !== 8'h00 || oRDY !== 1'b1 || oDONE !== 2'b00) begin fails++; $display("FAIL t5_async_rst: got ce=%b st=%b cnt=%h rdy=%b done=%b want 11 00 00 1 00", oCE, oST, oSKCNT, oRDY, oDONE); end
    cyc();
    iRSTn = 1'b1;
  endtask

`ifdef SKIP_GATED_CLK_EN
  task automatic test_gated();
    do_reset();
    load(0, 16'h0005, 3, 1'b0);
    cyc(); iLD = 1'b0;
    cyc();
    for (int s = 2; s < 10; s++) begin
      tests++; if (oCLK !== {1'b1, 1'(s % 2 == 0)}) begin fails++; $display("FAIL t6_high s%0d: got %b want %b", s, oCLK, {1'b1, 1'(s % 2 == 0)}); end
      #2;
      tests++; if (oCLK !== {1'b1, 1'(s % 2 == 0)}) begin fails++; $display("FAIL t6_midhigh s%0d: got %b want %b", s, oCLK, {1'b1, 1'(s % 2 == 0)}); end
      #3;
      tests++; if (oCLK !== 2'b00) begin fails++; $display("FAIL t6_low s%0d: got %b want 00", s, oCLK); end
      cyc();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_continuous();
    test_reload();
    test_oneshot();
    test_freeze();
    test_saturate();
`ifdef SKIP_GATED_CLK_EN
    test_gated();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
